// File: rtl/axis_pool_sched.sv
// rtl/axis_pool_sched.sv - round-robin window scheduler sharing one KxK pooling engine
// Grants whole K*K-beat windows and steers engine results back via a tag FIFO of owners.
module axis_pool_sched #(
  parameter int C_DATA_WIDTH = 8,
  parameter int NUM_REQ      = 4,
  parameter int K            = 2,
  parameter int TAG_DEPTH    = 4
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_REQ-1:0]                s_axis_tvalid,
  output logic [NUM_REQ-1:0]                s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]           e_m_axis_tdata,
  output logic                              e_m_axis_tvalid,
  input  logic                              e_m_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]           e_s_axis_tdata,
  input  logic                              e_s_axis_tvalid,
  output logic                              e_s_axis_tready,
  output logic [NUM_REQ*C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_REQ-1:0]                m_axis_tvalid,
  input  logic [NUM_REQ-1:0]                m_axis_tready,
  output logic                              busy,
  output logic [$clog2(NUM_REQ)-1:0]        cur_grant
);

  localparam int GW  = $clog2(NUM_REQ);
  localparam int WIN = K * K;
  localparam int BW  = $clog2(WIN) + 1;
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_d;
  logic [GW-1:0]   last_grant, last_grant_d;
  logic [BW-1:0]   beat_cnt, beat_cnt_d;

  logic            req_found;
  logic [GW-1:0]   req_idx;
  logic [GW-1:0]   cand;

  logic [GW-1:0]   tag_mem [TAG_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   tag_cnt;
  logic            fifo_empty, fifo_full;
  logic [GW-1:0]   head;

  logic            fwd_hs, last_beat, push, pop;

  // First valid requester strictly after last_grant, wrapping at NUM_REQ.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!req_found && s_axis_tvalid[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  assign e_m_axis_tdata = s_axis_tdata[cur_grant*C_DATA_WIDTH +: C_DATA_WIDTH];
  assign fwd_hs         = (state_q == BURST) && s_axis_tvalid[cur_grant] && e_m_axis_tready;
  assign last_beat      = (beat_cnt == BW'(WIN - 1));
  assign push           = fwd_hs && last_beat;

  always_comb begin
    state_d         = state_q;
    grant_d         = cur_grant;
    last_grant_d    = last_grant;
    beat_cnt_d      = beat_cnt;
    s_axis_tready   = '0;
    e_m_axis_tvalid = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_found && !fifo_full) begin
          state_d    = BURST;
          grant_d    = req_idx;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        e_m_axis_tvalid          = s_axis_tvalid[cur_grant];
        s_axis_tready[cur_grant] = e_m_axis_tready;
        if (fwd_hs) begin
          if (last_beat) begin
            state_d      = IDLE;
            last_grant_d = cur_grant;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cur_grant  <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      cur_grant  <= grant_d;
      last_grant <= last_grant_d;
      beat_cnt   <= beat_cnt_d;
    end
  end

  // Tag FIFO: one owner entry per granted window, consumed in window order.
  assign fifo_empty = (tag_cnt == '0);
  assign fifo_full  = (tag_cnt == CW'(TAG_DEPTH));
  assign head       = tag_mem[rd_ptr];
  assign pop        = e_s_axis_tvalid && e_s_axis_tready;

  always_ff @(posedge aclk) begin
    if (push) begin
      tag_mem[wr_ptr] <= cur_grant;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + CW'(1);
        2'b01:   tag_cnt <= tag_cnt - CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_comb begin
    m_axis_tvalid = '0;
    if (!fifo_empty) begin
      m_axis_tvalid[head] = e_s_axis_tvalid;
    end
  end

  assign e_s_axis_tready = !fifo_empty && m_axis_tready[head];
  assign m_axis_tdata    = {NUM_REQ{e_s_axis_tdata}};
  assign busy            = (state_q == BURST) || !fifo_empty;

endmodule

// File: tb/tb_axis_pool_sched.sv
// tb/tb_axis_pool_sched.sv - directed self-checking bench for axis_pool_sched
// The bench plays the requesters, the pooling engine and the result consumers.
module tb_axis_pool_sched;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tvalid;
  logic [3:0]  s_axis_tready;
  logic [7:0]  e_m_axis_tdata;
  logic        e_m_axis_tvalid;
  logic        e_m_axis_tready;
  logic [7:0]  e_s_axis_tdata;
  logic        e_s_axis_tvalid;
  logic        e_s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tvalid;
  logic [3:0]  m_axis_tready;
  logic        busy;
  logic [1:0]  cur_grant;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] beats1 [4] = '{8'd3, 8'd9, 8'd2, 8'd5};
  logic [7:0] bp     [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  axis_pool_sched #(
    .C_DATA_WIDTH(8), .NUM_REQ(4), .K(2), .TAG_DEPTH(4)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .e_m_axis_tdata  (e_m_axis_tdata),
    .e_m_axis_tvalid (e_m_axis_tvalid),
    .e_m_axis_tready (e_m_axis_tready),
    .e_s_axis_tdata  (e_s_axis_tdata),
    .e_s_axis_tvalid (e_s_axis_tvalid),
    .e_s_axis_tready (e_s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .busy            (busy),
    .cur_grant       (cur_grant)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_data(input int r, input logic [7:0] d);
    s_axis_tdata[r*8 +: 8] = d;
  endtask

  initial begin
    int exp_g;
    int idx;
    logic rdy;

    aresetn         = 1'b0;
    s_axis_tdata    = '0;
    s_axis_tvalid   = '0;
    e_m_axis_tready = 1'b1;
    e_s_axis_tdata  = '0;
    e_s_axis_tvalid = 1'b0;
    m_axis_tready   = 4'hF;

    // Reset state
    #3;
    check("rst_s_tready", s_axis_tready, 4'h0);
    check("rst_e_m_tvalid", e_m_axis_tvalid, 1'b0);
    check("rst_m_tvalid", m_axis_tvalid, 4'h0);
    check("rst_e_s_tready", e_s_axis_tready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cur_grant", cur_grant, 2'd0);
    tick();
    aresetn = 1'b1;

    // Single requester 1
    s_axis_tvalid = 4'b0010;
    set_data(1, beats1[0]);
    #1;
    check("single_idle_tready", s_axis_tready, 4'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_data(1, beats1[i]);
      #1;
      if (i == 0) check("single_cur_grant", cur_grant, 2'd1);
      check("single_e_m_tdata", e_m_axis_tdata, beats1[i]);
      check("single_e_m_tvalid", e_m_axis_tvalid, 1'b1);
      check("single_s_tready", s_axis_tready, 4'b0010);
      tick();
    end
    s_axis_tvalid = 4'b0000;
    #1;
    check("single_done_e_m_tvalid", e_m_axis_tvalid, 1'b0);
    check("single_done_busy", busy, 1'b1);
    e_s_axis_tdata  = 8'd9;
    e_s_axis_tvalid = 1'b1;
    #1;
    check("single_m_tvalid", m_axis_tvalid, 4'b0010);
    check("single_m_tdata", m_axis_tdata[15:8], 8'd9);
    check("single_e_s_tready", e_s_axis_tready, 1'b1);
    tick();
    e_s_axis_tvalid = 1'b0;
    #1;
    check("single_idle_busy", busy, 1'b0);

    // Round robin between requesters 0 and 2 from a fresh reset
    aresetn = 1'b0;
    #2;
    aresetn = 1'b1;
    set_data(0, 8'h10);
    set_data(2, 8'h20);
    s_axis_tvalid   = 4'b0101;
    e_s_axis_tdata  = 8'h77;
    e_s_axis_tvalid = 1'b1;
    tick();
    for (int w = 0; w < 6; w++) begin
      exp_g = (w % 2 == 1) ? 2 : 0;
      check("rr_cur_grant", cur_grant, exp_g);
      check("rr_s_tready", s_axis_tready, 4'b0001 << exp_g);
      check("rr_e_m_tdata", e_m_axis_tdata, (exp_g == 0) ? 8'h10 : 8'h20);
      for (int j = 0; j < 4; j++) tick();
      if (w == 5) s_axis_tvalid = 4'b0000;
      #1;
      check("rr_bubble_tready", s_axis_tready, 4'h0);
      check("rr_bubble_e_m_tvalid", e_m_axis_tvalid, 1'b0);
      tick();
    end
    e_s_axis_tvalid = 1'b0;
    check("rr_end_busy", busy, 1'b0);

    // Engine backpressure toggling every cycle, requester 3
    s_axis_tvalid = 4'b1000;
    set_data(3, bp[0]);
    tick();
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      rdy = (c % 2 == 1);
      e_m_axis_tready = rdy;
      set_data(3, bp[idx]);
      #1;
      check("bp_s_tready", s_axis_tready, rdy ? 4'b1000 : 4'b0000);
      check("bp_e_m_tvalid", e_m_axis_tvalid, 1'b1);
      check("bp_e_m_tdata", e_m_axis_tdata, bp[idx]);
      if (rdy) idx++;
      tick();
    end
    s_axis_tvalid   = 4'b0000;
    e_m_axis_tready = 1'b1;
    #1;
    check("bp_done_e_m_tvalid", e_m_axis_tvalid, 1'b0);
    check("bp_done_busy", busy, 1'b1);
    e_s_axis_tdata  = 8'h44;
    e_s_axis_tvalid = 1'b1;
    #1;
    check("bp_m_tvalid", m_axis_tvalid, 4'b1000);
    tick();
    e_s_axis_tvalid = 1'b0;
    #1;
    check("bp_end_busy", busy, 1'b0);

    // Tag FIFO full with all result consumers stalled
    m_axis_tready   = 4'h0;
    e_s_axis_tdata  = 8'h55;
    e_s_axis_tvalid = 1'b1;
    s_axis_tvalid   = 4'b0011;
    tick();
    for (int w = 0; w < 4; w++) begin
      check("full_cur_grant", cur_grant, w % 2);
      for (int j = 0; j < 4; j++) tick();
      if (w < 3) tick();
    end
    check("full_s_tready", s_axis_tready, 4'h0);
    check("full_e_m_tvalid", e_m_axis_tvalid, 1'b0);
    check("full_busy", busy, 1'b1);
    check("full_m_tvalid", m_axis_tvalid, 4'b0001);
    check("full_e_s_tready", e_s_axis_tready, 1'b0);
    tick();
    check("full_no_grant", s_axis_tready, 4'h0);
    check("full_busy_hold", busy, 1'b1);
    m_axis_tready = 4'b0001;
    #1;
    check("full_pop_ready", e_s_axis_tready, 1'b1);
    tick();
    m_axis_tready = 4'h0;
    #1;
    check("full_after_pop_idle", s_axis_tready, 4'h0);
    check("full_new_head", m_axis_tvalid, 4'b0010);
    tick();
    check("full_regrant", cur_grant, 2'd0);
    check("full_regrant_tready", s_axis_tready, 4'b0001);
    s_axis_tvalid = 4'b0001;
    for (int j = 0; j < 4; j++) tick();
    s_axis_tvalid = 4'b0000;
    m_axis_tready = 4'hF;
    for (int p = 0; p < 4; p++) begin
      #1;
      check("full_drain_order", m_axis_tvalid, (p % 2 == 0) ? 4'b0010 : 4'b0001);
      tick();
    end
    e_s_axis_tvalid = 1'b0;
    #1;
    check("full_drain_busy", busy, 1'b0);

    // Mixed return backpressure: windows to 3 then 0, consumer 3 stalled
    m_axis_tready   = 4'b0111;
    e_s_axis_tdata  = 8'hA3;
    e_s_axis_tvalid = 1'b1;
    s_axis_tvalid   = 4'b1000;
    tick();
    check("mix_grant3", cur_grant, 2'd3);
    for (int j = 0; j < 4; j++) tick();
    s_axis_tvalid = 4'b0001;
    #1;
    check("mix_hold3_tvalid", m_axis_tvalid, 4'b1000);
    check("mix_hold3_tready", e_s_axis_tready, 1'b0);
    tick();
    check("mix_grant0", cur_grant, 2'd0);
    for (int j = 0; j < 4; j++) tick();
    s_axis_tvalid = 4'b0000;
    #1;
    check("mix_order_tvalid", m_axis_tvalid, 4'b1000);
    check("mix_order_tready", e_s_axis_tready, 1'b0);
    tick();
    check("mix_still_held", m_axis_tvalid, 4'b1000);
    m_axis_tready = 4'hF;
    #1;
    check("mix_release_tready", e_s_axis_tready, 1'b1);
    check("mix_release_tdata3", m_axis_tdata[31:24], 8'hA3);
    tick();
    e_s_axis_tdata = 8'hB0;
    #1;
    check("mix_second_tvalid", m_axis_tvalid, 4'b0001);
    check("mix_second_tdata0", m_axis_tdata[7:0], 8'hB0);
    tick();
    e_s_axis_tvalid = 1'b0;
    #1;
    check("mix_end_busy", busy, 1'b0);

    // Reset in the middle of a window with a result pending
    m_axis_tready = 4'h0;
    s_axis_tvalid = 4'b0110;
    tick();
    check("rstmid_grant1", cur_grant, 2'd1);
    for (int j = 0; j < 4; j++) tick();
    tick();
    check("rstmid_grant2", cur_grant, 2'd2);
    tick();
    tick();
    e_s_axis_tvalid = 1'b1;
    #1;
    check("rstmid_pre_m_tvalid", m_axis_tvalid, 4'b0010);
    check("rstmid_pre_s_tready", s_axis_tready, 4'b0100);
    aresetn = 1'b0;
    #1;
    check("rstmid_s_tready", s_axis_tready, 4'h0);
    check("rstmid_e_m_tvalid", e_m_axis_tvalid, 1'b0);
    check("rstmid_m_tvalid", m_axis_tvalid, 4'h0);
    check("rstmid_e_s_tready", e_s_axis_tready, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_cur_grant", cur_grant, 2'd0);
    e_s_axis_tvalid = 1'b0;
    s_axis_tvalid   = 4'hF;
    aresetn         = 1'b1;
    tick();
    check("rstmid_next_grant", cur_grant, 2'd0);
    check("rstmid_next_tready", s_axis_tready, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
